// File: rtl/dmem_port_if.sv
// Requester-side bus for one data-memory port: request/command fields driven by
// the requester, grant and read return driven by the arbiter.
interface dmem_port_if #(
    parameter int ADDR_W = 32
);
    logic              REQ;
    logic              WE;
    logic [3:0]        BE;
    logic [ADDR_W-1:0] ADDR;
    logic [31:0]       WDATA;
    logic              GNT;
    logic              RVALID;
    logic [31:0]       RDATA;

    modport master (
        output REQ, WE, BE, ADDR, WDATA,
        input  GNT, RVALID, RDATA
    );

    modport slave (
        input  REQ, WE, BE, ADDR, WDATA,
        output GNT, RVALID, RDATA
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter in front of a single-port data memory: one access per cycle,
// burst-limited ownership, and 1-cycle-late read data routed back to its owner.
module dmem_port_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int BURST_MAX = 4
) (
    input  logic              CLK,
    input  logic              RST,
    dmem_port_if.slave        M0,
    dmem_port_if.slave        M1,
    output logic              MEM_EN,
    output logic [3:0]        MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [31:0]       MEM_WDATA,
    input  logic [31:0]       MEM_RDATA
);

    localparam int RUN_W = $clog2(BURST_MAX + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(BURST_MAX);

    logic [1:0]        req;
    logic [1:0]        we;
    logic [3:0]        be    [2];
    logic [ADDR_W-1:0] addr  [2];
    logic [31:0]       wdata [2];

    assign req      = {M1.REQ, M0.REQ};
    assign we       = {M1.WE, M0.WE};
    assign be[0]    = M0.BE;
    assign be[1]    = M1.BE;
    assign addr[0]  = M0.ADDR;
    assign addr[1]  = M1.ADDR;
    assign wdata[0] = M0.WDATA;
    assign wdata[1] = M1.WDATA;

    logic             last_reg, last_next;
    logic [RUN_W-1:0] run_reg, run_next;
    logic             rd_pend_reg, rd_pend_next;
    logic             rd_owner_reg, rd_owner_next;
    logic [1:0]       req_wait_reg;

    logic [1:0] gnt;
    logic       any_gnt;
    logic       gnt_port;
    logic       burst_open;

    // RUN==0 means nobody holds a streak, so a tie goes to the port that was not
    // served last; this is what lets port 0 win the first tie out of reset.
    assign burst_open = (run_reg != '0) && (run_reg < RUN_MAX);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            // Under contention: keep the current owner while its burst is open,
            // otherwise hand over to the other port.
            assign gnt[gi] = !RST && req[gi] &&
                             (!req[1-gi] || ((last_reg == 1'(gi)) == burst_open));

            // A requester must keep REQ up until it has been granted.
            assert property (@(posedge CLK) !(!RST && req_wait_reg[gi] && !req[gi]));
        end
    endgenerate

    assign any_gnt  = |gnt;
    assign gnt_port = gnt[1];

    always_comb begin
        MEM_EN    = any_gnt;
        MEM_ADDR  = addr[gnt_port];
        MEM_WDATA = wdata[gnt_port];
        MEM_WE    = (any_gnt && we[gnt_port]) ? be[gnt_port] : 4'b0000;
    end

    always_comb begin
        last_next     = last_reg;
        run_next      = run_reg;
        rd_pend_next  = 1'b0;
        rd_owner_next = rd_owner_reg;
        if (any_gnt) begin
            if (gnt_port == last_reg) begin
                run_next = (run_reg == RUN_MAX) ? run_reg : run_reg + 1'b1;
            end else begin
                last_next = gnt_port;
                run_next  = RUN_W'(1);
            end
            if (!we[gnt_port]) begin
                rd_pend_next  = 1'b1;
                rd_owner_next = gnt_port;
            end
        end else begin
            run_next = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            last_reg     <= 1'b1;
            run_reg      <= '0;
            rd_pend_reg  <= 1'b0;
            rd_owner_reg <= 1'b0;
            req_wait_reg <= 2'b00;
        end else begin
            last_reg     <= last_next;
            run_reg      <= run_next;
            rd_pend_reg  <= rd_pend_next;
            rd_owner_reg <= rd_owner_next;
            req_wait_reg <= req & ~gnt;
        end
    end

    assign M0.GNT    = gnt[0];
    assign M1.GNT    = gnt[1];
    assign M0.RVALID = !RST && rd_pend_reg && !rd_owner_reg;
    assign M1.RVALID = !RST && rd_pend_reg && rd_owner_reg;
    assign M0.RDATA  = MEM_RDATA;
    assign M1.RDATA  = MEM_RDATA;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: two instances (BURST_MAX 4 and 1) share one
// directed stimulus, each checked every cycle against a rule-level model.
module tb_dmem_port_arbiter;

    localparam int LOGN = 512;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic [1:0]  want = 2'b00;
    logic [1:0]  f_we = 2'b00;
    logic [3:0]  f_be    [2] = '{4'h0, 4'h0};
    logic [31:0] f_addr  [2] = '{32'h0, 32'h0};
    logic [31:0] f_wdata [2] = '{32'h0, 32'h0};

    logic [1:0]  hold_k [2] = '{2'b00, 2'b00};
    logic [1:0]  req_k  [2];
    logic [1:0]  gnt_k  [2];
    logic [1:0]  rv_k   [2];
    logic [31:0] rdata0_k [2];
    logic [31:0] rdata1_k [2];
    logic        mem_en_k    [2];
    logic [3:0]  mem_we_k    [2];
    logic [31:0] mem_addr_k  [2];
    logic [31:0] mem_wdata_k [2];
    logic [31:0] mem_rdata_k [2];
    logic [31:0] mem [2][256];

    int cycle_no = 0;
    int t1 = 0, t2 = 0, t3 = 0, t5 = 0, t6 = 0;
    bit stim_done = 1'b0;
    bit idle_timeout = 1'b0;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cfg
            dmem_port_if #(.ADDR_W(32)) m0_if ();
            dmem_port_if #(.ADDR_W(32)) m1_if ();

            assign m0_if.REQ   = want[0] | hold_k[gi][0];
            assign m0_if.WE    = f_we[0];
            assign m0_if.BE    = f_be[0];
            assign m0_if.ADDR  = f_addr[0];
            assign m0_if.WDATA = f_wdata[0];
            assign m1_if.REQ   = want[1] | hold_k[gi][1];
            assign m1_if.WE    = f_we[1];
            assign m1_if.BE    = f_be[1];
            assign m1_if.ADDR  = f_addr[1];
            assign m1_if.WDATA = f_wdata[1];

            dmem_port_arbiter #(
                .ADDR_W   (32),
                .BURST_MAX((gi == 0) ? 4 : 1)
            ) u_dut (
                .CLK      (clk),
                .RST      (rst),
                .M0       (m0_if),
                .M1       (m1_if),
                .MEM_EN   (mem_en_k[gi]),
                .MEM_WE   (mem_we_k[gi]),
                .MEM_ADDR (mem_addr_k[gi]),
                .MEM_WDATA(mem_wdata_k[gi]),
                .MEM_RDATA(mem_rdata_k[gi])
            );

            assign req_k[gi]    = {m1_if.REQ, m0_if.REQ};
            assign gnt_k[gi]    = {m1_if.GNT, m0_if.GNT};
            assign rv_k[gi]     = {m1_if.RVALID, m0_if.RVALID};
            assign rdata0_k[gi] = m0_if.RDATA;
            assign rdata1_k[gi] = m1_if.RDATA;
        end
    endgenerate

    // Memory behind each arbiter plus the per-instance "hold REQ until granted" latch.
    always @(posedge clk) begin
        cycle_no <= cycle_no + 1;
        for (int k = 0; k < 2; k++) begin
            hold_k[k] <= rst ? 2'b00 : (req_k[k] & ~gnt_k[k]);
            if (rst) begin
                mem[k][64] <= 32'h1234_5678;
                mem[k][65] <= 32'hCAFE_F00D;
            end else if (mem_en_k[k]) begin
                if (mem_we_k[k] == 4'b0000) begin
                    mem_rdata_k[k] <= mem[k][mem_addr_k[k][9:2]];
                end else begin
                    for (int b = 0; b < 4; b++) begin
                        if (mem_we_k[k][b])
                            mem[k][mem_addr_k[k][9:2]][8*b +: 8] <= mem_wdata_k[k][8*b +: 8];
                    end
                end
            end
        end
    end

    int vectors = 0;
    int miscompares = 0;

    int          m_last  [2] = '{1, 1};
    int          m_run   [2] = '{0, 0};
    bit          m_pend  [2] = '{1'b0, 1'b0};
    int          m_owner [2] = '{0, 0};
    logic [31:0] m_rdata [2];
    logic [31:0] shadow  [2][256];

    int          gnt_log [2][LOGN];
    logic [1:0]  rv_log  [2][LOGN];
    logic [31:0] rd_log  [2][LOGN];
    logic [3:0]  we_log  [2][LOGN];

    function void chk(string name, int k, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cfg%0d cycle %0d: got %h expected %h", name, k, cycle_no, act, exp);
        end
    endfunction

    function void summary();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    endfunction

    always @(negedge clk) begin : compare
        int eg;
        int bm;
        int idx;
        int c;
        logic [1:0] exp_rv;
        c = cycle_no % LOGN;
        for (int k = 0; k < 2; k++) begin
            bm = (k == 0) ? 4 : 1;
            // Who must be served this cycle (2 = nobody).
            if (rst)                  eg = 2;
            else if (req_k[k] == 2'b11)
                eg = (m_run[k] > 0 && m_run[k] < bm) ? m_last[k] : 1 - m_last[k];
            else if (req_k[k][0])     eg = 0;
            else if (req_k[k][1])     eg = 1;
            else                      eg = 2;

            chk("gnt", k, {30'b0, gnt_k[k]}, (eg == 2) ? 32'd0 : ((eg == 0) ? 32'd1 : 32'd2));
            chk("mem_en", k, {31'b0, mem_en_k[k]}, {31'b0, eg != 2});
            if (eg != 2) begin
                chk("mem_addr", k, mem_addr_k[k], f_addr[eg]);
                chk("mem_we", k, {28'b0, mem_we_k[k]}, f_we[eg] ? {28'b0, f_be[eg]} : 32'd0);
                if (f_we[eg]) chk("mem_wdata", k, mem_wdata_k[k], f_wdata[eg]);
            end else begin
                chk("mem_we_idle", k, {28'b0, mem_we_k[k]}, 32'd0);
            end

            exp_rv = (!rst && m_pend[k]) ? ((m_owner[k] == 0) ? 2'b01 : 2'b10) : 2'b00;
            chk("rvalid", k, {30'b0, rv_k[k]}, {30'b0, exp_rv});
            if (rv_k[k][0]) chk("m0_rdata", k, rdata0_k[k], m_rdata[k]);
            if (rv_k[k][1]) chk("m1_rdata", k, rdata1_k[k], m_rdata[k]);

            gnt_log[k][c] = (gnt_k[k] == 2'b01) ? 0 : (gnt_k[k] == 2'b10) ? 1 : 2;
            rv_log[k][c]  = rv_k[k];
            rd_log[k][c]  = rv_k[k][1] ? rdata1_k[k] : rdata0_k[k];
            we_log[k][c]  = mem_we_k[k];

            // State the model must be in after the coming edge.
            if (rst) begin
                m_last[k]     = 1;
                m_run[k]      = 0;
                m_pend[k]     = 1'b0;
                m_owner[k]    = 0;
                shadow[k][64] = 32'h1234_5678;
                shadow[k][65] = 32'hCAFE_F00D;
            end else if (eg == 2) begin
                m_run[k]  = 0;
                m_pend[k] = 1'b0;
            end else begin
                if (eg == m_last[k]) begin
                    m_run[k] = (m_run[k] < bm) ? m_run[k] + 1 : bm;
                end else begin
                    m_last[k] = eg;
                    m_run[k]  = 1;
                end
                idx = int'(f_addr[eg][9:2]);
                if (f_we[eg]) begin
                    for (int b = 0; b < 4; b++)
                        if (f_be[eg][b]) shadow[k][idx][8*b +: 8] = f_wdata[eg][8*b +: 8];
                    m_pend[k] = 1'b0;
                end else begin
                    m_pend[k]  = 1'b1;
                    m_owner[k] = eg;
                    m_rdata[k] = shadow[k][idx];
                end
            end
        end

        if (cycle_no > 3000) begin
            vectors++;
            miscompares++;
            $display("FAIL watchdog: stimulus still running at cycle %0d, limit 3000", cycle_no);
            summary();
            $finish;
        end

        if (stim_done) begin
            // Hand-computed pins for the directed scenarios.
            vectors++;
            if (idle_timeout) begin
                miscompares++;
                $display("FAIL idle_drain: requests still held after 20 cycles, expected drained");
            end
            chk("lit_reset_gnt", 0, gnt_log[0][1], 2);
            chk("lit_t1_gnt", 0, gnt_log[0][t1], 0);
            chk("lit_t1_rv", 0, {30'b0, rv_log[0][t1+1]}, 32'd1);
            chk("lit_t1_rdata", 0, rd_log[0][t1+1], 32'h1234_5678);
            chk("lit_t2_we", 0, {28'b0, we_log[0][t2]}, 32'h0000_000F);
            chk("lit_t2_rv", 0, {30'b0, rv_log[0][t2+2]}, 32'd1);
            chk("lit_t2_rdata", 0, rd_log[0][t2+2], 32'hDEAD_BEEF);
            for (int i = 0; i < 10; i++)
                chk("lit_burst4", 0, gnt_log[0][t3+i], ((i >= 4) && (i < 8)) ? 32'd1 : 32'd0);
            for (int i = 0; i < 6; i++)
                chk("lit_burst1", 1, gnt_log[1][t3+i], i % 2);
            chk("lit_burst1_rv_a", 1, {30'b0, rv_log[1][t3+1]}, 32'd1);
            chk("lit_burst1_rv_b", 1, {30'b0, rv_log[1][t3+2]}, 32'd2);
            chk("lit_t5_m0", 0, gnt_log[0][t5+9], 0);
            chk("lit_t5_m1", 0, gnt_log[0][t5+10], 1);
            for (int k = 0; k < 2; k++) begin
                chk("lit_t6_rd_gnt", k, gnt_log[k][t6-1], 1);
                chk("lit_t6_rv_a", k, {30'b0, rv_log[k][t6]}, 32'd0);
                chk("lit_t6_rv_b", k, {30'b0, rv_log[k][t6+1]}, 32'd0);
                chk("lit_t6_tie", k, gnt_log[k][t6+2], 0);
            end
            summary();
            $finish;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((hold_k[0] != 2'b00 || hold_k[1] != 2'b00) && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) idle_timeout = 1'b1;
        tick();
    endtask

    task automatic set_reads();
        f_we[0] = 1'b0; f_be[0] = 4'h0; f_addr[0] = 32'h100;
        f_we[1] = 1'b0; f_be[1] = 4'h0; f_addr[1] = 32'h104;
    endtask

    initial begin
        rst = 1'b1;
        tick();
        tick();
        // 1: lone port-0 read straight out of reset
        rst = 1'b0;
        set_reads();
        want = 2'b01;
        t1 = cycle_no;
        tick();
        want = 2'b00;
        drain();

        // 2: port-1 write, then port-0 reads it back
        f_we[1] = 1'b1; f_be[1] = 4'hF; f_addr[1] = 32'h200; f_wdata[1] = 32'hDEAD_BEEF;
        want = 2'b10;
        t2 = cycle_no;
        tick();
        f_we[0] = 1'b0; f_addr[0] = 32'h200;
        want = 2'b01;
        tick();
        want = 2'b00;
        drain();

        // 3/4: continuous contention from reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_reads();
        want = 2'b11;
        t3 = cycle_no;
        repeat (10) tick();
        want = 2'b00;
        drain();

        // 5: port 0 alone for 10 cycles, then port 1 joins
        want = 2'b01;
        t5 = cycle_no;
        repeat (10) tick();
        want = 2'b11;
        tick();
        want = 2'b00;
        drain();

        // 6: read granted just before reset, then a tie after release
        want = 2'b10;
        tick();
        t6 = cycle_no;
        rst = 1'b1;
        want = 2'b00;
        tick();
        tick();
        rst = 1'b0;
        want = 2'b11;
        tick();
        want = 2'b00;
        drain();
        repeat (2) tick();
        stim_done = 1'b1;
    end

endmodule
